// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encoding and width helpers for the nibble-serial adder.
package serial_add_pkg;
    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
    localparam int NIBBLE_W = 4;
    function automatic int nibbles(input int width);
        return width / NIBBLE_W;
    endfunction
    function automatic int cnt_w(input int width);
        return (nibbles(width) > 1) ? $clog2(nibbles(width)) : 1;
    endfunction
endpackage

// File: rtl/add_slice4.sv
// add_slice4: combinational 4-bit carry-select adder slice.
module add_slice4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);
    logic [4:0] s0, s1;
    assign s0 = {1'b0, a} + {1'b0, b};
    assign s1 = {1'b0, a} + {1'b0, b} + 5'd1;
    assign {c_out, s} = c_in ? s1 : s0;
endmodule

// File: rtl/serial_nibble_add_ctrl.sv
// serial_nibble_add_ctrl: WIDTH-bit add/subtract sequenced one nibble per clock
// through a single carry-select slice, with Busy/Done handshake.
module serial_nibble_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic             Busy,
    output logic             Done
);
    localparam int N  = nibbles(WIDTH);
    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, part_q, part_d, sum_q, sum_d;
    logic             carry_q, carry_d, a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic             cout_q, cout_d, ovf_q, ovf_d;
    logic [3:0]       s;
    logic             c_out;

    add_slice4 u_slice (
        .a    (opa_q[3:0]),
        .b    (opb_q[3:0]),
        .c_in (carry_q),
        .s    (s),
        .c_out(c_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        part_d  = part_q;
        carry_d = carry_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (Run) begin
                state_d = COMPUTE;
                opa_d   = A;
                opb_d   = Sub ? ~B : B;
                carry_d = Sub;
                cnt_d   = '0;
                part_d  = '0;
                a_msb_d = A[WIDTH-1];
                b_msb_d = Sub ? ~B[WIDTH-1] : B[WIDTH-1];
            end
            COMPUTE: begin
                opa_d   = opa_q >> NIBBLE_W;
                opb_d   = opb_q >> NIBBLE_W;
                part_d  = WIDTH'({s, part_q} >> NIBBLE_W);
                carry_d = c_out;
                cnt_d   = cnt_q + CW'(1);
                // Only the last nibble step publishes results; partials stay internal.
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    sum_d   = part_d;
                    cout_d  = c_out;
                    ovf_d   = (a_msb_q == b_msb_q) && (part_d[WIDTH-1] != a_msb_q);
                end
            end
            DONE: if (!Run) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            part_q  <= '0;
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            part_q  <= part_d;
            carry_q <= carry_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Sum  = sum_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;
    assign Busy = (state_q == COMPUTE);
    assign Done = (state_q == DONE);
endmodule

// File: tb/tb_serial_nibble_add_ctrl.sv
// tb_serial_nibble_add_ctrl: directed and random operations checked against an
// integer-arithmetic reference model, including latency, handshake and reset abort.
module tb_serial_nibble_add_ctrl;
    localparam int W = 16;
    localparam int N = W / 4;

    logic         Clk = 1'b0;
    logic         Reset, Run, Sub, Cout, Ovf, Busy, Done;
    logic [W-1:0] A, B, Sum;
    int           n_vec = 0, n_err = 0;
    logic [W-1:0] exp_sum = '0;
    logic         exp_cout = 1'b0, exp_ovf = 1'b0;

    serial_nibble_add_ctrl #(.WIDTH(W)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Sub(Sub), .A(A), .B(B),
        .Sum(Sum), .Cout(Cout), .Ovf(Ovf), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                  output logic [W-1:0] s, output logic c, output logic o);
        int sa, sb, r;
        sa = $signed(a);
        sb = $signed(b);
        r  = sub ? sa - sb : sa + sb;
        s  = W'(r);
        c  = sub ? (int'(a) >= int'(b)) : ((int'(a) + int'(b)) >= (1 << W));
        o  = (r > 32767) || (r < -32768);
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_sum"}, 32'(Sum), 32'(exp_sum));
        check({tag, "_cout"}, 32'(Cout), 32'(exp_cout));
        check({tag, "_ovf"}, 32'(Ovf), 32'(exp_ovf));
        check({tag, "_busy"}, 32'(Busy), 0);
        check({tag, "_done"}, 32'(Done), 0);
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input int hold);
        logic [W-1:0] s;
        logic c, o;
        model(a, b, sub, s, c, o);
        @(negedge Clk);
        A = a; B = b; Sub = sub; Run = 1'b1;
        @(posedge Clk); #1;
        for (int i = 0; i < N; i++) begin
            check("busy", 32'(Busy), 1);
            check("done_in_compute", 32'(Done), 0);
            check("sum_stable", 32'(Sum), 32'(exp_sum));
            A = W'($urandom); B = W'($urandom); Sub = 1'($urandom);
            @(posedge Clk); #1;
        end
        exp_sum = s; exp_cout = c; exp_ovf = o;
        check("done", 32'(Done), 1);
        check("busy_at_done", 32'(Busy), 0);
        check("sum", 32'(Sum), 32'(exp_sum));
        check("cout", 32'(Cout), 32'(exp_cout));
        check("ovf", 32'(Ovf), 32'(exp_ovf));
        for (int i = 0; i < hold; i++) begin
            A = W'($urandom); B = W'($urandom);
            @(posedge Clk); #1;
            check("done_hold", 32'(Done), 1);
            check("busy_hold", 32'(Busy), 0);
            check("sum_hold", 32'(Sum), 32'(exp_sum));
        end
        @(negedge Clk);
        Run = 1'b0;
        @(posedge Clk); #1;
        check_idle_outputs("release");
    endtask

    initial begin
        Reset = 1'b1; Run = 1'b0; Sub = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check_idle_outputs("reset");

        op(16'h1234, 16'h0FFF, 1'b0, 0);
        op(16'hFFFF, 16'h0001, 1'b0, 0);
        op(16'h7FFF, 16'h0001, 1'b0, 1);
        op(16'h0005, 16'h0007, 1'b1, 0);
        op(16'h8000, 16'h0001, 1'b1, 2);
        op(16'hABCD, 16'h1357, 1'b0, 20);

        // Abort in the second compute cycle; nothing partial may leak out.
        @(negedge Clk);
        A = 16'h4321; B = 16'h1111; Sub = 1'b0; Run = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk); #1;
        exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
        check_idle_outputs("abort");
        @(negedge Clk);
        Reset = 1'b0; Run = 1'b0;
        op(16'h4321, 16'h1111, 1'b0, 0);

        for (int t = 0; t < 30; t++)
            op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/serial_nibble_add_ctrl.md
# serial_nibble_add_ctrl

Multi-cycle controller that performs a WIDTH-bit add or subtract by stepping one 4-bit carry-select adder slice across the operands, one nibble per clock, least significant nibble first. It sits between the lab's switch/register front end and the display logic, and replaces a full-width combinational adder. It latches operands on a Run request and sequences the slice with a registered inter-nibble carry. It presents a registered result with carry-out and signed-overflow flags, plus a Busy/Done handshake.

## Interface
- WIDTH, 16: operand/result width in bits; must be a multiple of 4 and at least 4.
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high; forces IDLE and clears all outputs.
- Run  in  1  level request; sampled only in IDLE; must drop before the next operation is accepted.
- Sub  in  1  0 = A+B, 1 = A−B; sampled with operands.
- A  in  WIDTH  operand A; sampled with Run in IDLE.
- B  in  WIDTH  operand B; sampled with Run in IDLE.
- Sum  out  WIDTH  registered result; holds last completed result.
- Cout  out  1  carry out of bit WIDTH−1 (for subtract, 1 = no borrow).
- Ovf  out  1  two's-complement overflow of the completed operation.
- Busy  out  1  high while nibbles are being computed.
- Done  out  1  high while a completed result is held awaiting Run release.

## Operation
- States: IDLE, COMPUTE, DONE (one-hot or encoded, package enum).
- IDLE:
  - If Run=1, latch opA←A and opB←(Sub ? ~B : B), carry←Sub, nibble count←0, and capture the operand sign bits for overflow.
  - Then go to COMPUTE. Otherwise hold.
- COMPUTE:
  - Each cycle, feed the slice with opA[3:0], opB[3:0] and carry.
  - Shift opA and opB right by 4 bits.
  - Shift the slice sum into the top nibble of the partial register, which shifts right by 4.
  - carry←slice c_out; count++.
  - On the cycle where count = NIBBLES−1, write Sum←final partial value (the final nibble included) and Cout←slice c_out.
  - In the same cycle, set Ovf←(a_msb == b_eff_msb) && (sum_msb ≠ a_msb), then go to DONE.
- DONE: Done=1. Stay while Run=1; when Run=0, go to IDLE.
- Run is ignored in COMPUTE and in DONE, apart from the release check. Holding Run high yields exactly one operation.
- A, B and Sub changes after the sampling edge have no effect on the operation in flight.
- Sum, Cout and Ovf change only on a completion edge or on Reset, never with partial values.
- Width rules:
  - NIBBLES = WIDTH/4.
  - Count width is clog2(NIBBLES), with a minimum of 1 bit.
  - Arithmetic is modulo 2^WIDTH.

## Timing
- Reset values: Sum=0, Cout=0, Ovf=0, Busy=0, Done=0, state=IDLE. All partial registers and the count are zeroed.
- Run high at edge k in IDLE:
  - Busy=1 after edge k.
  - Result is valid and Done=1 after edge k+NIBBLES, with Busy=0 in the same cycle.
  - Latency is NIBBLES+1 edges (5 for WIDTH=16).
- Busy and Done are never high together. Both are decoded directly from registered state.
- Reset during COMPUTE or DONE takes effect at that edge: the operation is aborted, no partial result is exposed, and outputs return to their reset values.
- Reset and Run high on the same edge: Reset wins. The next edge may then accept Run.
- Back-to-back operations need a minimum of 1 cycle with Run=0 (DONE→IDLE), then the next Run sample.

## Structure
- Package serial_add_pkg contains:
  - the state typedef enum {IDLE, COMPUTE, DONE};
  - localparam NIBBLE_W = 4;
  - a function computing NIBBLES and the count width from WIDTH.
- One sub-module, add_slice4: a purely combinational 4-bit carry-select adder (A[3:0], B[3:0], c_in → S[3:0], c_out). The controller instantiates exactly one add_slice4.
- The controller holds the state register, the count, the opA/opB shift registers, the partial-sum register, the carry flip-flop and the captured sign bits.

## Test plan
- Reset, then idle 3 cycles → Sum=0x0000, Cout=0, Ovf=0, Busy=0, Done=0.
- Add 0x1234+0x0FFF, Sub=0 → after 5 edges Sum=0x2233, Cout=0, Ovf=0, Done=1. Busy is high for exactly 4 cycles.
- Add 0xFFFF+0x0001 → Sum=0x0000, Cout=1, Ovf=0. Add 0x7FFF+0x0001 → Sum=0x8000, Cout=0, Ovf=1 (inter-nibble carry ripple through all four steps).
- Sub 0x0005−0x0007 → Sum=0xFFFE, Cout=0, Ovf=0. Sub 0x8000−0x0001 → Sum=0x7FFF, Cout=1, Ovf=1.
- Hold Run=1 for 20 cycles while changing A/B after the sampling edge → exactly one operation; result reflects the sampled operands; Done stays high until Run=0, then IDLE.
- Assert Reset at the 2nd COMPUTE cycle → all outputs 0 next cycle and no stale Sum. A new Run afterwards completes correctly with 5-edge latency.
